// File: rtl/dma_regfile_pkg.sv
// Shared definitions for the multi-channel DMA register file.
//   - Byte offsets of the per-channel registers inside a 32-byte channel window.
//   - Bit positions of the CMD register fields.
//   - APB phase FSM encoding.
//   - is_protected(): registers that may not be written while the channel is busy.
package dma_regfile_pkg;

  localparam logic [4:0] OFF_RD_START = 5'h00;
  localparam logic [4:0] OFF_WR_START = 5'h04;
  localparam logic [4:0] OFF_BUF_SIZE = 5'h08;
  localparam logic [4:0] OFF_CMD      = 5'h0C;
  localparam logic [4:0] OFF_START    = 5'h10;
  localparam logic [4:0] OFF_STATUS   = 5'h14;
  localparam logic [4:0] OFF_INT_STAT = 5'h18;
  localparam logic [4:0] OFF_INT_EN   = 5'h1C;

  localparam int CMD_SET_INT_BIT = 0;
  localparam int CMD_LAST_BIT    = 1;
  localparam int CMD_NEXT_LSB    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  function automatic logic is_protected(input logic [4:0] off);
    return off inside {OFF_RD_START, OFF_WR_START, OFF_BUF_SIZE, OFF_CMD, OFF_START};
  endfunction

endpackage

// File: rtl/dma_regfile_mc_if.sv
// APB bus bundle for dma_regfile_mc.
//   master: drives pclken, psel, penable, paddr, pwrite, pwdata.
//   slave : drives prdata, pslverr, pready.
// Handshake: a transfer is one SETUP cycle (psel & !penable) followed by one
// ACCESS cycle (psel & penable); the slave holds pready = 1 throughout ACCESS,
// so every ACCESS completes in one pclken-qualified cycle. All phases only
// advance on clk edges where pclken = 1.
interface dma_regfile_mc_if #(
  parameter int ADDR_BITS = 16
) ();
  logic                 pclken;
  logic                 psel;
  logic                 penable;
  logic [ADDR_BITS-1:0] paddr;
  logic                 pwrite;
  logic [31:0]          pwdata;
  logic [31:0]          prdata;
  logic                 pslverr;
  logic                 pready;

  modport master (
    output pclken, psel, penable, paddr, pwrite, pwdata,
    input  prdata, pslverr, pready
  );

  modport slave (
    input  pclken, psel, penable, paddr, pwrite, pwdata,
    output prdata, pslverr, pready
  );
endinterface

// File: rtl/dma_ch_regs.sv
// One DMA channel's register set.
//   we        : write commit for this channel (already error-filtered by the top)
//   reg_off   : byte offset of the addressed register
//   wdata     : write data
//   busy      : channel engine active; blocks descriptor/START writes
//   int_event : one-cycle completion event
//   buf_cnt / int_cnt : live engine counters, shown in STATUS
//   rdata     : combinational read data for reg_off
//   rd_start, wr_start, buf_size, set_int, cmd_last, next_addr : descriptor
//   start_pulse : one-cycle pulse after a START commit
//   int_req   : pending & enable
module dma_ch_regs
  import dma_regfile_pkg::*;
#(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [4:0]          reg_off,
  input  logic [31:0]         wdata,
  input  logic                busy,
  input  logic                int_event,
  input  logic [CNT_BITS-1:0] buf_cnt,
  input  logic [CNT_BITS-1:0] int_cnt,
  output logic [31:0]         rdata,
  output logic [31:0]         rd_start,
  output logic [31:0]         wr_start,
  output logic [31:0]         buf_size,
  output logic                set_int,
  output logic                cmd_last,
  output logic [27:0]         next_addr,
  output logic                start_pulse,
  output logic                int_req
);

  logic pending;
  logic int_en;
  logic we_ok;

  // Second guard on busy: covers busy rising between SETUP and the commit.
  assign we_ok = we && !(busy && is_protected(reg_off));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_start    <= '0;
      wr_start    <= '0;
      buf_size    <= '0;
      set_int     <= 1'b0;
      cmd_last    <= 1'b0;
      next_addr   <= '0;
      start_pulse <= 1'b0;
      int_en      <= 1'b0;
      pending     <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (we_ok) begin
        case (reg_off)
          OFF_RD_START: rd_start <= wdata;
          OFF_WR_START: wr_start <= wdata;
          OFF_BUF_SIZE: buf_size <= wdata;
          OFF_CMD: begin
            set_int   <= wdata[CMD_SET_INT_BIT];
            cmd_last  <= wdata[CMD_LAST_BIT];
            next_addr <= wdata[31:CMD_NEXT_LSB];
          end
          OFF_START:  start_pulse <= wdata[0];
          OFF_INT_EN: int_en      <= wdata[0];
          default: ;
        endcase
      end
      // A completion event beats a simultaneous W1C clear.
      if (int_event && set_int) begin
        pending <= 1'b1;
      end else if (we_ok && reg_off == OFF_INT_STAT && wdata[0]) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      OFF_RD_START: rdata = rd_start;
      OFF_WR_START: rdata = wr_start;
      OFF_BUF_SIZE: rdata = buf_size;
      OFF_CMD:      rdata = {next_addr, 2'b00, cmd_last, set_int};
      OFF_STATUS:   rdata = {16'(int_cnt), 16'(buf_cnt)};
      OFF_INT_STAT: rdata = {31'd0, pending};
      OFF_INT_EN:   rdata = {31'd0, int_en};
      default:      rdata = '0;
    endcase
  end

  assign int_req = pending & int_en;

endmodule

// File: rtl/dma_regfile_mc.sv
// Multi-channel DMA register file with an APB slave port.
//   clk, reset    : clock, synchronous active-high reset
//   apb           : APB slave bundle (pclken-qualified)
//   buffer_count, int_count : per-channel engine counters (CNT_BITS each)
//   ch_busy, ch_int_event   : per-channel engine status / completion event
//   rd_start_addr, wr_start_addr, buffer_size, set_int, cmd_last, next_addr :
//                   per-channel descriptors
//   wr_ch_start   : per-channel one-cycle start pulse
//   irq           : registered OR of pending & enable
//   apb_state     : current APB phase FSM state
// Address map: paddr[7:5] = channel, paddr[4:2] = register, upper bits must be 0.
module dma_regfile_mc
  import dma_regfile_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int NUM_CH    = 4,
  parameter int CNT_BITS  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  dma_regfile_mc_if.slave            apb,
  input  logic [NUM_CH*CNT_BITS-1:0] buffer_count,
  input  logic [NUM_CH*CNT_BITS-1:0] int_count,
  input  logic [NUM_CH-1:0]          ch_busy,
  input  logic [NUM_CH-1:0]          ch_int_event,
  output logic [NUM_CH*32-1:0]       rd_start_addr,
  output logic [NUM_CH*32-1:0]       wr_start_addr,
  output logic [NUM_CH*32-1:0]       buffer_size,
  output logic [NUM_CH-1:0]          set_int,
  output logic [NUM_CH-1:0]          cmd_last,
  output logic [NUM_CH*28-1:0]       next_addr,
  output logic [NUM_CH-1:0]          wr_ch_start,
  output logic                       irq,
  output apb_state_t                 apb_state
);

  apb_state_t  state, state_next;
  logic [2:0]  ch;
  logic [4:0]  reg_off;
  logic [7:0]  busy_ext;
  logic        dec_err;
  logic        commit;
  logic [31:0] rd_mux;
  logic [31:0] ch_rdata [NUM_CH];
  logic [NUM_CH-1:0] int_req;
  logic        unused_paddr_lsb;

  assign ch               = apb.paddr[7:5];
  assign reg_off          = {apb.paddr[4:2], 2'b00};
  assign busy_ext         = 8'(ch_busy);
  assign unused_paddr_lsb = ^apb.paddr[1:0];

  assign dec_err = (|apb.paddr[ADDR_BITS-1:8])
                || (int'(ch) >= NUM_CH)
                || (apb.pwrite && reg_off == OFF_STATUS)
                || (apb.pwrite && busy_ext[ch] && is_protected(reg_off));

  // pslverr was evaluated during SETUP; a flagged transfer changes nothing.
  assign commit = (state == ST_ACCESS) && apb.pclken && apb.pwrite && !apb.pslverr;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (apb.pclken) begin
      unique case (state)
        ST_IDLE:   if (apb.psel && !apb.penable) state_next = ST_SETUP;
        ST_SETUP: begin
          if (apb.psel && apb.penable) state_next = ST_ACCESS;
          else if (apb.psel)           state_next = ST_SETUP;
          else                         state_next = ST_IDLE;
        end
        ST_ACCESS: state_next = (apb.psel && !apb.penable) ? ST_SETUP : ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  assign apb_state = state;
  assign apb.pready = (state == ST_ACCESS);

  // pslverr is also raised for psel & penable seen in IDLE (no SETUP phase);
  // that response shows in the cycle after the stray access while the FSM
  // stays IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
    end else if (apb.pclken) begin
      unique case (state)
        ST_IDLE:  apb.pslverr <= apb.psel && apb.penable;
        ST_SETUP: begin
          apb.pslverr <= apb.psel && apb.penable && dec_err;
          if (apb.psel && apb.penable)
            apb.prdata <= (!apb.pwrite && !dec_err) ? rd_mux : 32'd0;
        end
        default:  apb.pslverr <= 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(ch) == c) rd_mux = ch_rdata[c];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dma_ch_regs #(.CNT_BITS(CNT_BITS)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .we          (commit && int'(ch) == c),
      .reg_off     (reg_off),
      .wdata       (apb.pwdata),
      .busy        (ch_busy[c]),
      .int_event   (ch_int_event[c]),
      .buf_cnt     (buffer_count[c*CNT_BITS +: CNT_BITS]),
      .int_cnt     (int_count[c*CNT_BITS +: CNT_BITS]),
      .rdata       (ch_rdata[c]),
      .rd_start    (rd_start_addr[c*32 +: 32]),
      .wr_start    (wr_start_addr[c*32 +: 32]),
      .buf_size    (buffer_size[c*32 +: 32]),
      .set_int     (set_int[c]),
      .cmd_last    (cmd_last[c]),
      .next_addr   (next_addr[c*28 +: 28]),
      .start_pulse (wr_ch_start[c]),
      .int_req     (int_req[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |int_req;
  end

endmodule
